// File: rtl/ascon_pkg.sv
// ascon_pkg
//   Shared types and helpers for the ASCON permutation datapath.
//   t_state_array : five 64-bit state words x0..x4, indexed [row][bit]
//   C_MAX_ROUNDS  : number of rounds of a full p^a permutation
//   t_round_fsm   : state encoding of the round controller
//   round_constant: 8-bit constant XORed into x2 for a given round index
package ascon_pkg;

  typedef logic [4:0][63:0] t_state_array;

  localparam int C_MAX_ROUNDS = 12;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } t_round_fsm;

  // Upper nibble counts down from 0xF while the lower nibble counts up,
  // so index 0 gives 0xF0 and index 11 gives 0x4B.
  function automatic logic [7:0] round_constant(input logic [3:0] idx);
    return {4'hF - idx, idx};
  endfunction

endpackage

// File: rtl/permutation_round_controller.sv
// permutation_round_controller
//   Sequential front end of the ASCON permutation. Holds the 320-bit state
//   and the round index, applies the round constant to x2 before the
//   substitution layer, and loads the diffusion-layer output back each round.
//   A request runs 1..G_MAX_ROUNDS rounds (0 rounds passes the state through)
//   and the final state is returned with a valid/ready handshake.
//
// Ports
//   i_clock      : clock, rising edge
//   i_reset      : synchronous active-high reset
//   i_start      : start request, accepted only while o_ready=1
//   i_rounds     : round count for the request (clamped to G_MAX_ROUNDS)
//   i_state      : initial state, captured with i_start
//   o_ready      : controller idle and able to accept a request
//   o_state      : round input to the substitution layer
//   i_state_next : diffusion-layer output for the current o_state
//   o_valid      : final state available on o_result
//   i_ready      : downstream accepts o_result
//   o_result     : raw state register
module permutation_round_controller
  import ascon_pkg::*;
#(
  parameter int G_MAX_ROUNDS = C_MAX_ROUNDS
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [3:0]   i_rounds,
  input  t_state_array i_state,
  output logic         o_ready,
  output t_state_array o_state,
  input  t_state_array i_state_next,
  output logic         o_valid,
  input  logic         i_ready,
  output t_state_array o_result
);

  localparam logic [3:0] MAX_ROUNDS = 4'(G_MAX_ROUNDS);
  localparam logic [3:0] LAST_IDX   = 4'(G_MAX_ROUNDS - 1);

  t_round_fsm   fsm;
  t_round_fsm   fsm_next;
  logic [3:0]   idx;
  logic [3:0]   idx_next;
  t_state_array state_reg;
  t_state_array state_next;
  logic [3:0]   rounds_clamped;

  // Requests above the table size run the full permutation.
  always_comb begin
    rounds_clamped = (i_rounds > MAX_ROUNDS) ? MAX_ROUNDS : i_rounds;
  end

  // State register, round index and FSM state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      fsm       <= IDLE;
      idx       <= '0;
      state_reg <= '0;
    end else begin
      fsm       <= fsm_next;
      idx       <= idx_next;
      state_reg <= state_next;
    end
  end

  // Next-state logic and outputs. The index starts at G_MAX_ROUNDS-n so a
  // short request always ends on the last constants of the table.
  always_comb begin
    fsm_next   = fsm;
    idx_next   = idx;
    state_next = state_reg;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    o_state    = state_reg;

    case (fsm)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          state_next = i_state;
          idx_next   = MAX_ROUNDS - rounds_clamped;
          fsm_next   = (rounds_clamped == 4'd0) ? DONE : RUN;
        end
      end

      RUN: begin
        o_state[2][7:0] = state_reg[2][7:0] ^ round_constant(idx);
        state_next      = i_state_next;
        idx_next        = idx + 4'd1;
        if (idx == LAST_IDX) begin
          fsm_next = DONE;
        end
      end

      DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          fsm_next = IDLE;
        end
      end

      default: begin
        fsm_next = IDLE;
      end
    endcase
  end

  assign o_result = state_reg;

endmodule

// File: tb/tb_permutation_round_controller.sv
// tb_permutation_round_controller
//   Scoreboard bench for permutation_round_controller. The driver issues
//   requests and pushes the expected final state; a monitor on the falling
//   edge pops and compares whenever o_valid rises.
module tb_permutation_round_controller;
  import ascon_pkg::*;

  localparam int MAXR = 12;

  logic         i_clock = 1'b0;
  logic         i_reset;
  logic         i_start;
  logic [3:0]   i_rounds;
  t_state_array i_state;
  logic         o_ready;
  t_state_array o_state;
  t_state_array i_state_next;
  logic         o_valid;
  logic         i_ready;
  t_state_array o_result;

  logic loop_mode;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  typedef struct {
    t_state_array init;
    int           n;
    t_state_array exp;
    int           accept;
  } txn_t;

  txn_t         sb_q[$];
  txn_t         cur;
  logic         prev_valid = 1'b0;
  t_state_array held;

  permutation_round_controller #(.G_MAX_ROUNDS(MAXR)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_rounds    (i_rounds),
    .i_state     (i_state),
    .o_ready     (o_ready),
    .o_state     (o_state),
    .i_state_next(i_state_next),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result)
  );

  always #5 i_clock = ~i_clock;

  // Edge counter: after active edge k, cyc == k.
  always @(posedge i_clock) cyc <= cyc + 1;

  // Stand-in for the S-box/diffusion path: identity, or a scrambling mix
  // that makes round ordering and constant placement observable.
  function automatic t_state_array mix(input t_state_array s);
    t_state_array m;
    for (int k = 0; k < 5; k++) begin
      m[k] = {s[(k + 1) % 5][50:0], s[(k + 1) % 5][63:51]} ^ (s[k] >> 7) ^ 64'h9E3779B97F4A7C15;
    end
    return m;
  endfunction

  assign i_state_next = loop_mode ? mix(o_state) : o_state;

  function automatic logic [7:0] ref_const(input int i);
    return 8'(((15 - i) << 4) | i);
  endfunction

  // Reference permutation: n rounds using the last n constants of the table.
  function automatic t_state_array model(input t_state_array s, input int n, input logic mode);
    t_state_array t;
    t = s;
    for (int r = 0; r < n; r++) begin
      t[2][7:0] = t[2][7:0] ^ ref_const(MAXR - n + r);
      if (mode) t = mix(t);
    end
    return t;
  endfunction

  function automatic t_state_array rand_state();
    t_state_array s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: first-round constant, valid latency, result and stability.
  always @(negedge i_clock) begin
    if (!i_reset) begin
      if (sb_q.size() > 0 && cyc == sb_q[0].accept) begin
        t_state_array e;
        e = sb_q[0].init;
        if (sb_q[0].n > 0) e[2][7:0] = e[2][7:0] ^ ref_const(MAXR - sb_q[0].n);
        checkOutput("first_round_state", o_state, e);
      end
      if (o_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_valid", {319'd0, o_valid}, 320'd0);
        end else begin
          cur  = sb_q.pop_front();
          held = cur.exp;
          checkOutput("result", o_result, cur.exp);
          checkOutput("valid_latency", 320'(cyc - cur.accept), 320'(cur.n));
        end
      end else if (o_valid && prev_valid) begin
        checkOutput("result_stable", o_result, held);
      end
    end
    prev_valid = o_valid;
  end

  task automatic applyStimulus(input t_state_array init, input logic [3:0] rounds, input int hold);
    txn_t t;
    int   guard;
    guard = 0;
    while (!o_ready && guard < 100) begin
      @(posedge i_clock); #1;
      guard++;
    end
    if (!o_ready) begin
      checkOutput("ready_timeout", {319'd0, o_ready}, 320'd1);
      return;
    end
    t.init   = init;
    t.n      = (rounds > 4'(MAXR)) ? MAXR : int'(rounds);
    t.exp    = model(init, t.n, loop_mode);
    t.accept = cyc + 1;
    sb_q.push_back(t);
    i_start  = 1'b1;
    i_rounds = rounds;
    i_state  = init;
    i_ready  = (hold == 0);
    @(posedge i_clock); #1;
    i_start = 1'b0;
    i_state = rand_state();
    guard = 0;
    while (!o_valid && guard < 100) begin
      @(posedge i_clock); #1;
      guard++;
    end
    if (!o_valid) begin
      checkOutput("valid_timeout", {319'd0, o_valid}, 320'd1);
      return;
    end
    // Backpressure: starts offered while DONE must be ignored.
    for (int h = 0; h < hold; h++) begin
      i_start  = 1'b1;
      i_rounds = 4'($urandom_range(0, 15));
      @(posedge i_clock); #1;
    end
    i_start = (hold > 0);
    i_ready = 1'b1;
    @(posedge i_clock); #1;
    i_start = 1'b0;
    checkOutput("ready_after_handshake", {319'd0, o_ready}, 320'd1);
    checkOutput("valid_after_handshake", {319'd0, o_valid}, 320'd0);
  endtask

  task automatic resetMidRun();
    txn_t t;
    loop_mode = 1'b0;
    t.init   = '0;
    t.n      = MAXR;
    t.exp    = '0;
    t.accept = cyc + 1;
    sb_q.push_back(t);
    i_start  = 1'b1;
    i_rounds = 4'd12;
    i_state  = '0;
    @(posedge i_clock); #1;
    i_start = 1'b0;
    repeat (3) begin
      @(posedge i_clock); #1;
    end
    i_reset = 1'b1;
    sb_q.delete();
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    checkOutput("midrun_reset_ready", {319'd0, o_ready}, 320'd1);
    checkOutput("midrun_reset_valid", {319'd0, o_valid}, 320'd0);
    checkOutput("midrun_reset_state", o_state, 320'd0);
    checkOutput("midrun_reset_result", o_result, 320'd0);
    for (int k = 0; k < 12; k++) begin
      @(posedge i_clock); #1;
      checkOutput("no_valid_after_reset", {319'd0, o_valid}, 320'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset   = 1'b1;
    i_start   = 1'b0;
    i_rounds  = '0;
    i_state   = '0;
    i_ready   = 1'b1;
    loop_mode = 1'b0;
    repeat (2) @(posedge i_clock);
    #1;
    checkOutput("reset_ready", {319'd0, o_ready}, 320'd1);
    checkOutput("reset_valid", {319'd0, o_valid}, 320'd0);
    checkOutput("reset_state", o_state, 320'd0);
    checkOutput("reset_result", o_result, 320'd0);
    i_reset = 1'b0;

    applyStimulus('0, 4'd12, 0);
    applyStimulus('0, 4'd6, 0);
    applyStimulus('0, 4'd1, 0);
    applyStimulus(rand_state(), 4'd0, 0);
    applyStimulus('0, 4'd15, 0);
    applyStimulus(rand_state(), 4'd12, 5);
    applyStimulus(rand_state(), 4'd0, 3);

    loop_mode = 1'b1;
    applyStimulus(rand_state(), 4'd4, 2);

    resetMidRun();
    loop_mode = 1'b0;
    applyStimulus('0, 4'd8, 0);

    for (int k = 0; k < 24; k++) begin
      loop_mode = 1'($urandom_range(0, 1));
      applyStimulus(rand_state(), 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge i_clock);
    #1;
    if (sb_q.size() != 0) begin
      checkOutput("scoreboard_drained", 320'(sb_q.size()), 320'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
